gon_mcc_fifo: RTL and testbench

Buffered multicast controller for the global-network (GON) buses of the PE array. It compares each bus transaction's tag against NUM_ID scan-programmed ID entries and enqueues matching data into a local FIFO. The FIFO drains to the attached PE under valid/ready. Non-matching transactions never stall the bus, and a full FIFO back-pressures only the transactions it would accept.

---
 rtl/gon_mcc_fifo_pkg.sv | 26 ++
 rtl/gon_fifo.sv | 51 +++++
 rtl/gon_mcc_fifo.sv | 82 ++++++++
 tb/tb_gon_mcc_fifo.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gon_mcc_fifo_pkg.sv
// Shared widths and the entry layout for the GON multicast controller.
// Build option GON_MCC_MASK_EN adds a per-entry don't-care mask field.
package gon_pkg;

  localparam int GON_TAG_W = 4;

  function automatic int gon_entry_w(input int tag_w);
`ifdef GON_MCC_MASK_EN
    return 2 * tag_w + 1;
`else
    return tag_w + 1;
`endif
  endfunction

  function automatic int gon_cfg_w(input int num_id, input int tag_w);
    return num_id * gon_entry_w(tag_w);
  endfunction

  // Field order matches the scan chain, MSB first; mask is unused without GON_MCC_MASK_EN.
  typedef struct packed {
    logic                 en;
    logic [GON_TAG_W-1:0] mask;
    logic [GON_TAG_W-1:0] id;
  } gon_entry_t;

endpackage

// File: rtl/gon_fifo.sv
// Circular buffer with occupancy count; head is presented without a read strobe.
module gon_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                push,
  input  logic                                pop,
  input  logic [DATA_WIDTH-1:0]               din,
  output logic [DATA_WIDTH-1:0]               dout,
  output logic                                full,
  output logic                                empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? '0 : mem[rptr];

  // Storage holds data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // Depth is a power of two, so pointers wrap naturally at AW bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/gon_mcc_fifo.sv
// GON bus multicast controller: scan-programmed tag match feeding a local FIFO to the PE.
// Build option GON_MCC_MASK_EN enables per-entry tag masks (longer config chain).
module gon_mcc_fifo
  import gon_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 4,
  parameter int NUM_ID     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_WIDTH-1:0]             data_in,
  input  logic [TAG_WIDTH-1:0]              tag,
  input  logic                              valid_in,
  output logic                              ready_out,
  output logic [DATA_WIDTH-1:0]             data_out,
  output logic                              valid_out,
  input  logic                              ready_in,
  input  logic                              scan_en_id,
  input  logic                              scan_in_id,
  output logic                              scan_out_id,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int EW    = gon_entry_w(TAG_WIDTH);
  localparam int CFG_W = gon_cfg_w(NUM_ID, TAG_WIDTH);

  logic [CFG_W-1:0] cfg;
  logic [EW-1:0]    entry;
  logic             match;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          cfg <= '0;
    else if (scan_en_id) cfg <= {cfg[CFG_W-2:0], scan_in_id};
  end

  assign scan_out_id = cfg[CFG_W-1];

  // Match is suppressed during shifting: partially loaded entries must never accept traffic.
  always_comb begin
    match = 1'b0;
    entry = '0;
    for (int k = 0; k < NUM_ID; k++) begin
      entry = cfg[k*EW +: EW];
`ifdef GON_MCC_MASK_EN
      if (entry[EW-1] &&
          (((tag ^ entry[TAG_WIDTH-1:0]) & ~entry[2*TAG_WIDTH-1:TAG_WIDTH]) == '0))
        match = 1'b1;
`else
      if (entry[EW-1] && (tag == entry[TAG_WIDTH-1:0]))
        match = 1'b1;
`endif
    end
    if (scan_en_id) match = 1'b0;
  end

  assign ready_out = ~match | ~full;
  assign push      = valid_in & match & ~full;
  assign valid_out = ~empty;
  assign pop       = valid_out & ready_in;

  gon_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (data_in),
    .dout  (data_out),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_gon_mcc_fifo.sv
// Directed bench for gon_mcc_fifo; the mask section is compiled when GON_MCC_MASK_EN is defined.
module tb_gon_mcc_fifo;
  import gon_pkg::*;

  localparam int DW    = 64;
  localparam int TW    = 4;
  localparam int NID   = 2;
  localparam int DEPTH = 4;
  localparam int CFG_W = gon_cfg_w(NID, TW);

`ifdef GON_MCC_MASK_EN
  localparam logic [CFG_W-1:0] CFG_EXACT3 = {9'b0, 1'b1, 4'b0000, 4'h3};
  localparam logic [CFG_W-1:0] CFG_RANGE  = {9'b0, 1'b1, 4'b0011, 4'b0100};
`else
  localparam logic [CFG_W-1:0] CFG_EXACT3 = {5'b0, 1'b1, 4'h3};
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in;
  logic [TW-1:0] tag;
  logic          valid_in;
  logic          ready_out;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          ready_in;
  logic          scan_en_id;
  logic          scan_in_id;
  logic          scan_out_id;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;

  int n_assert = 0;
  int n_fail   = 0;

  gon_mcc_fifo #(
    .DATA_WIDTH (DW),
    .TAG_WIDTH  (TW),
    .NUM_ID     (NID),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .tag         (tag),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .scan_en_id  (scan_en_id),
    .scan_in_id  (scan_in_id),
    .scan_out_id (scan_out_id),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic scan_cfg(input logic [CFG_W-1:0] w);
    scan_en_id = 1'b1;
    for (int i = CFG_W - 1; i >= 0; i--) begin
      scan_in_id = w[i];
      tick();
    end
    scan_en_id = 1'b0;
    scan_in_id = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    data_in    = '0;
    tag        = '0;
    valid_in   = 1'b0;
    ready_in   = 1'b0;
    scan_en_id = 1'b0;
    scan_in_id = 1'b0;
    #2;
    chk("rst_valid_out", valid_out, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_scan_out", scan_out_id, 0);
    chk("rst_ready_out", ready_out, 1);
    #10 reset = 1'b1;
    tick();

    // single matching push
    scan_cfg(CFG_EXACT3);
    chk("cfg_scan_out", scan_out_id, 0);
    tag = 4'h3; data_in = 64'hA5; valid_in = 1'b1;
    settle();
    chk("t1_ready", ready_out, 1);
    tick();
    valid_in = 1'b0;
    settle();
    chk("t1_valid_out", valid_out, 1);
    chk("t1_data_out", data_out, 64'hA5);
    chk("t1_count", fifo_count, 1);
    ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    settle();
    chk("t1_drain_count", fifo_count, 0);
    chk("t1_drain_valid", valid_out, 0);
    chk("t1_drain_data", data_out, 0);

    // non-matching traffic is ignored and never stalled
    tag = 4'h5; data_in = 64'hDEAD; valid_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("t2_ready", ready_out, 1);
      tick();
      chk("t2_count", fifo_count, 0);
      chk("t2_valid_out", valid_out, 0);
    end

    // fill to full, back-pressure, then drain
    tag = 4'h3;
    for (int i = 1; i <= 4; i++) begin
      data_in = 64'(i);
      settle();
      chk("t3_ready_fill", ready_out, 1);
      tick();
    end
    data_in = 64'd5;
    settle();
    chk("t3_full_count", fifo_count, 4);
    chk("t3_full_ready", ready_out, 0);
    ready_in = 1'b1;
    settle();
    chk("t3_head1", data_out, 1);
    chk("t3_ready_same_cycle", ready_out, 0);
    tick();
    chk("t3_count_after_pop", fifo_count, 3);
    chk("t3_head2", data_out, 2);
    chk("t3_ready_next_cycle", ready_out, 1);
    tick();
    valid_in = 1'b0;
    settle();
    chk("t3_count_pushpop", fifo_count, 3);
    chk("t3_head3", data_out, 3);
    tick();
    chk("t3_head4", data_out, 4);
    chk("t3_count2", fifo_count, 2);
    tick();
    chk("t3_head5", data_out, 5);
    chk("t3_count1", fifo_count, 1);
    tick();
    chk("t3_empty_count", fifo_count, 0);
    chk("t3_empty_valid", valid_out, 0);
    ready_in = 1'b0;

    // sustained push+pop at occupancy 2 across pointer wrap
    valid_in = 1'b1;
    data_in = 64'd10;
    tick();
    data_in = 64'd11;
    tick();
    chk("t4_prefill", fifo_count, 2);
    ready_in = 1'b1;
    for (int j = 0; j < 8; j++) begin
      data_in = 64'(12 + j);
      settle();
      chk("t4_order", data_out, 64'(10 + j));
      chk("t4_count", fifo_count, 2);
      tick();
    end
    valid_in = 1'b0;
    settle();
    chk("t4_tail18", data_out, 18);
    tick();
    chk("t4_tail19", data_out, 19);
    tick();
    chk("t4_drained", fifo_count, 0);
    ready_in = 1'b0;

    // bus traffic during scan is dropped; ones propagate through the chain
    tag = 4'h3; data_in = 64'hBAD; valid_in = 1'b1;
    scan_en_id = 1'b1; scan_in_id = 1'b1;
    for (int i = 0; i < CFG_W; i++) begin
      settle();
      chk("t5_scan_ready", ready_out, 1);
      tick();
      chk("t5_scan_count", fifo_count, 0);
    end
    scan_in_id = 1'b0;
    for (int i = 0; i < CFG_W; i++) begin
      settle();
      chk("t5_scan_out_one", scan_out_id, 1);
      tick();
    end
    chk("t5_scan_out_zero", scan_out_id, 0);
    chk("t5_no_push", valid_out, 0);
    valid_in = 1'b0;
    scan_en_id = 1'b0;

`ifdef GON_MCC_MASK_EN
    // range multicast: tags 4..7 accepted, tag 8 ignored
    scan_cfg(CFG_RANGE);
    valid_in = 1'b1;
    for (int t = 4; t <= 7; t++) begin
      tag = 4'(t); data_in = 64'(t);
      settle();
      chk("t6_mask_ready", ready_out, 1);
      tick();
    end
    chk("t6_mask_count", fifo_count, 4);
    tag = 4'h8;
    settle();
    chk("t6_tag8_ready", ready_out, 1);
    tick();
    chk("t6_tag8_count", fifo_count, 4);
    chk("t6_tag8_head", data_out, 4);
    tag = 4'h4;
    settle();
    chk("t6_tag4_full", ready_out, 0);
`else
    // exact compare: only tag 3 is accepted
    scan_cfg(CFG_EXACT3);
    valid_in = 1'b1;
    tag = 4'h3; data_in = 64'h31;
    tick();
    tag = 4'h2; data_in = 64'h22;
    tick();
    tag = 4'h3; data_in = 64'h33;
    tick();
    chk("t6_exact_count", fifo_count, 2);
    chk("t6_exact_head", data_out, 64'h31);
    tag = 4'h2;
    settle();
    chk("t6_exact_ready", ready_out, 1);
`endif

    // asynchronous reset mid-stream clears buffered data at once
    #2 reset = 1'b0;
    #1;
    chk("t7_rst_valid", valid_out, 0);
    chk("t7_rst_count", fifo_count, 0);
    chk("t7_rst_data", data_out, 0);
    chk("t7_rst_ready", ready_out, 1);
    chk("t7_rst_scan_out", scan_out_id, 0);
    valid_in = 1'b0;
    #3 reset = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
